// File: rtl/multi_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control FSM:
//   - 4-bit state encodings (S_*)
//   - instruction opcodes (OP_*)
//   - ALU operation codes (ALUOP_*)
//   - ALU B-input select and PC-source select encodings (ALUSRCB_*, PCSRC_*)
//   - ctrl_t, the bundle of every datapath control signal
//   No ports (package).
// ---------------------------------------------------------------------------
package multi_cycle_ctrl_pkg;

  // FSM state encodings
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd15;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation requested from alu_control
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  // ALU B-input select
  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every control signal the FSM drives into the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_next_state.sv
// ---------------------------------------------------------------------------
// mc_next_state
//   Purely combinational next-state logic for multi_cycle_ctrl.
//   Ports:
//     state       in  4  current FSM state
//     opcode      in  6  live IR opcode, consulted only in DECODE
//     opcode_lat  in  6  opcode captured in DECODE, used by MEMADR (lw vs sw)
//     mem_ready   in  1  memory completed this cycle (FETCH/MEMRD/MEMWR only)
//     next_state  out 4  state for the next clock
// ---------------------------------------------------------------------------
module mc_next_state
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] opcode_lat,
  input  logic       mem_ready,
  output logic [3:0] next_state
);

  always_comb begin
    next_state = S_HALT;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: next_state = S_EXEC;
          OP_LW:    next_state = S_MEMADR;
          OP_SW:    next_state = S_MEMADR;
          OP_BEQ:   next_state = S_BRANCH;
          OP_ADDI:  next_state = S_ADDIEX;
          OP_J:     next_state = S_JUMP;
          default:  next_state = S_HALT;
        endcase
      end
      // Only lw and sw reach MEMADR, so "not sw" means lw.
      S_MEMADR: next_state = (opcode_lat == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      // Unused encodings can only come from an upset; park in HALT so it is visible.
      default:  next_state = S_HALT;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Moore control FSM for the multi-cycle MIPS datapath (fetch, decode,
//   execute, memory, writeback). Supports R-type, lw, sw, beq, addi, j;
//   any other opcode halts the core until rst.
//   Optional feature macro: MC_PERF_EN adds instr_cnt / stall_cnt counters.
//   Ports:
//     clk, rst (sync, active high)
//     opcode[5:0]   IR[31:26], sampled in DECODE
//     mem_ready     memory finished the current access this cycle
//     pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//     alu_op[ALUOP_W-1:0], pc_source[1:0]   datapath controls
//     state_o[3:0]  current state (debug), illegal  high in HALT
//     instr_cnt, stall_cnt [COUNT_W-1:0]    only with MC_PERF_EN
// ---------------------------------------------------------------------------
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state_o,
  output logic               illegal
`ifdef MC_PERF_EN
  ,
  output logic [COUNT_W-1:0] instr_cnt,
  output logic [COUNT_W-1:0] stall_cnt
`endif
);

  logic [3:0] state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  ctrl_t      ctrl;

  // Capture the opcode in DECODE so later states do not depend on the IR.
  assign opcode_d = (state_q == S_DECODE) ? opcode : opcode_q;

  mc_next_state u_next_state (
    .state      (state_q),
    .opcode     (opcode),
    .opcode_lat (opcode_q),
    .mem_ready  (mem_ready),
    .next_state (state_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Output decode from the current state. The only mem_ready dependence is
  // the FETCH writes: PC and IR load only on the cycle the read completes.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_HALT: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALUOP_W'(ctrl.alu_op);
  assign pc_source     = ctrl.pc_source;
  assign illegal       = ctrl.illegal;
  assign state_o       = state_q;

`ifdef MC_PERF_EN
  logic [COUNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               wait_state;

  // States in which the FSM is waiting on memory.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_FETCH) && mem_ready) begin
      instr_cnt_d = instr_cnt_q + COUNT_W'(1);
    end
    if (wait_state && !mem_ready) begin
      stall_cnt_d = stall_cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed testbench for multi_cycle_ctrl. Each cycle applies an opcode and
//   mem_ready value and compares state_o and the full control word against
//   hand-written constants. With MC_PERF_EN defined, the counters are checked.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  // Expected states
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9;
  localparam logic [3:0] ST_ADDIWB = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;
  localparam logic [3:0] ST_HALT   = 4'd15;

  // Control word field order:
  // pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg
  // reg_dst reg_write alu_src_a alu_src_b[2] alu_op[3] pc_source[2] illegal
  localparam logic [17:0] C_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_000_00_0;
  localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_000_00_0;
  localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_000_00_0;
  localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [17:0] C_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_000_00_0;
  localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_000_00_0;
  localparam logic [17:0] C_MEMWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_000_00_0;
  localparam logic [17:0] C_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [17:0] C_ALUWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_000_00_0;
  localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [17:0] C_ADDIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_000_00_0;
  localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_000_10_0;
  localparam logic [17:0] C_HALT    = 18'b0_0_0_0_0_0_0_0_0_0_00_000_00_1;

  localparam logic [5:0] O_R   = 6'b000000;
  localparam logic [5:0] O_LW  = 6'b100011;
  localparam logic [5:0] O_SW  = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100;
  localparam logic [5:0] O_ADI = 6'b001000;
  localparam logic [5:0] O_J   = 6'b000010;
  localparam logic [5:0] O_BAD = 6'b111111;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_o;
`ifdef MC_PERF_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  logic [17:0] ctrl_obs;
  int          n_vec;
  int          n_miss;

  assign ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal};

  multi_cycle_ctrl #(.COUNT_W(32), .ALUOP_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state_o       (state_o),
    .illegal       (illegal)
`ifdef MC_PERF_EN
    ,
    .instr_cnt     (instr_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, let the decode settle, compare, advance.
  task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                      input logic [3:0] exp_st, input logic [17:0] exp_c);
    opcode    = op;
    mem_ready = rdy;
    #2;
    chk({tag, "_st"}, 32'(state_o), 32'(exp_st));
    chk({tag, "_ctl"}, 32'(ctrl_obs), 32'(exp_c));
    chk({tag, "_excl"}, 32'(mem_read & mem_write), 32'd0);
    $display("cyc %-10s op=%b rdy=%b st=%0d ctl=%b", tag, op, rdy, state_o,
             ctrl_obs);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    opcode    = O_R;
    mem_ready = 1'b0;
    #1;

    // 1: reset, then FETCH with mem_read asserted and no writes
    do_reset();
    step("rst_f", O_R, 1'b0, ST_FETCH, C_FETCH_W);

    // 2: lw with memory always ready; opcode disturbed after DECODE
    step("lw_f",   O_LW, 1'b1, ST_FETCH,  C_FETCH_R);
    step("lw_d",   O_LW, 1'b1, ST_DECODE, C_DECODE);
    step("lw_ma",  O_SW, 1'b1, ST_MEMADR, C_MEMADR);
    step("lw_rd",  O_SW, 1'b1, ST_MEMRD,  C_MEMRD);
    step("lw_wb",  O_SW, 1'b1, ST_MEMWB,  C_MEMWB);

    // 3: sw with a fetch stall and 3 wait cycles in MEMWR
    step("sw_fw",  O_SW, 1'b0, ST_FETCH,  C_FETCH_W);
    step("sw_f",   O_SW, 1'b1, ST_FETCH,  C_FETCH_R);
    step("sw_d",   O_SW, 1'b1, ST_DECODE, C_DECODE);
    step("sw_ma",  O_LW, 1'b1, ST_MEMADR, C_MEMADR);
    for (int i = 0; i < 3; i++) step("sw_wait", O_LW, 1'b0, ST_MEMWR, C_MEMWR);
    step("sw_wr",  O_LW, 1'b1, ST_MEMWR,  C_MEMWR);

    // 4: R-type then beq (mem_ready low outside waits must be ignored)
    step("r_f",    O_R, 1'b1, ST_FETCH,  C_FETCH_R);
    step("r_d",    O_R, 1'b0, ST_DECODE, C_DECODE);
    step("r_ex",   O_R, 1'b0, ST_EXEC,   C_EXEC);
    step("r_wb",   O_R, 1'b0, ST_ALUWB,  C_ALUWB);
    step("beq_f",  O_BEQ, 1'b1, ST_FETCH,  C_FETCH_R);
    step("beq_d",  O_BEQ, 1'b1, ST_DECODE, C_DECODE);
    step("beq_br", O_BEQ, 1'b1, ST_BRANCH, C_BRANCH);

    // addi and j
    step("addi_f",  O_ADI, 1'b1, ST_FETCH,  C_FETCH_R);
    step("addi_d",  O_ADI, 1'b1, ST_DECODE, C_DECODE);
    step("addi_ex", O_ADI, 1'b1, ST_ADDIEX, C_ADDIEX);
    step("addi_wb", O_ADI, 1'b1, ST_ADDIWB, C_ADDIWB);
    step("j_f",     O_J, 1'b1, ST_FETCH,  C_FETCH_R);
    step("j_d",     O_J, 1'b1, ST_DECODE, C_DECODE);
    step("j_j",     O_J, 1'b1, ST_JUMP,   C_JUMP);

    // 5: illegal opcode halts; only rst leaves
    step("bad_f", O_BAD, 1'b1, ST_FETCH,  C_FETCH_R);
    step("bad_d", O_BAD, 1'b1, ST_DECODE, C_DECODE);
    for (int i = 0; i < 20; i++) step("halt", O_R, i[0], ST_HALT, C_HALT);
    do_reset();
    step("halt_rst", O_R, 1'b0, ST_FETCH, C_FETCH_W);

    // 6: rst during a MEMRD wait drops the read
    step("mr_f",  O_LW, 1'b1, ST_FETCH,  C_FETCH_R);
    step("mr_d",  O_LW, 1'b1, ST_DECODE, C_DECODE);
    step("mr_ma", O_LW, 1'b1, ST_MEMADR, C_MEMADR);
    step("mr_w0", O_LW, 1'b0, ST_MEMRD,  C_MEMRD);
    step("mr_w1", O_LW, 1'b0, ST_MEMRD,  C_MEMRD);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("mr_rst", O_LW, 1'b0, ST_FETCH, C_FETCH_W);

`ifdef MC_PERF_EN
    // 10 back-to-back j with memory ready: no stalls
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step("pj_f", O_J, 1'b1, ST_FETCH,  C_FETCH_R);
      step("pj_d", O_J, 1'b1, ST_DECODE, C_DECODE);
      step("pj_j", O_J, 1'b1, ST_JUMP,   C_JUMP);
    end
    chk("instr_cnt10", instr_cnt, 32'd10);
    chk("stall_cnt0",  stall_cnt, 32'd0);
    for (int i = 0; i < 3; i++) step("pst_f", O_J, 1'b0, ST_FETCH, C_FETCH_W);
    chk("instr_cnt_st", instr_cnt, 32'd10);
    chk("stall_cnt3",   stall_cnt, 32'd3);
    do_reset();
    chk("instr_cnt_rst", instr_cnt, 32'd0);
    chk("stall_cnt_rst", stall_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
